// File: rtl/exec_stage_if.sv
// Execute-stage bus: ID/EX operands and controls in, registered EX/MEM results out.
interface exec_stage_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic [1:0]      alu_op;
  logic            alu_src;
  logic [2:0]      funct3;
  logic            funct7_30;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [XLEN-1:0] result_adder;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] result_alu;
  logic            zero;
  logic [XLEN-1:0] muxout;
  logic            branch_taken;

  modport master (
    output stall, alu_op, alu_src, funct3, funct7_30, pc, imm, rd1, rd2,
    input  result_adder, alu_ctrl, result_alu, zero, muxout, branch_taken
  );

  modport slave (
    input  stall, alu_op, alu_src, funct3, funct7_30, pc, imm, rd1, rd2,
    output result_adder, alu_ctrl, result_alu, zero, muxout, branch_taken
  );
endinterface

// File: rtl/exec_stage.sv
// RV32I execute stage: ALU decode, operand-B mux, ALU, pc+imm adder, one EX/MEM register.
// Optional macro EXEC_BRANCH_COND_EN enables full branch-condition evaluation.
module exec_stage #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  exec_stage_if.slave  bus
);
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  logic [3:0]      ctrl_next;
  logic [XLEN-1:0] op_b_next;
  logic [XLEN-1:0] alu_next;
  logic [XLEN-1:0] adder_next;
  logic            zero_next;
  logic            branch_next;
  logic [4:0]      shamt;

  logic [3:0]      ctrl_reg;
  logic [XLEN-1:0] alu_reg;
  logic [XLEN-1:0] adder_reg;
  logic [XLEN-1:0] op_b_reg;
  logic            zero_reg;
  logic            branch_reg;

  assign op_b_next  = bus.alu_src ? bus.imm : bus.rd2;
  assign adder_next = bus.pc + bus.imm;
  assign shamt      = op_b_next[4:0];

  always_comb begin
    ctrl_next = ALU_ADD;
    case (bus.alu_op)
      2'b00: ctrl_next = ALU_ADD;
      2'b01: ctrl_next = ALU_SUB;
      default: begin
        case (bus.funct3)
          // I-type has no SUB: bit 30 belongs to the immediate there
          3'b000: ctrl_next = (bus.alu_op == 2'b10 && bus.funct7_30) ? ALU_SUB : ALU_ADD;
          3'b001: ctrl_next = ALU_SLL;
          3'b010: ctrl_next = ALU_SLT;
          3'b011: ctrl_next = ALU_SLTU;
          3'b100: ctrl_next = ALU_XOR;
          3'b101: ctrl_next = bus.funct7_30 ? ALU_SRA : ALU_SRL;
          3'b110: ctrl_next = ALU_OR;
          default: ctrl_next = ALU_AND;
        endcase
      end
    endcase
  end

  always_comb begin
    alu_next = '0;
    case (ctrl_next)
      ALU_AND:  alu_next = bus.rd1 & op_b_next;
      ALU_OR:   alu_next = bus.rd1 | op_b_next;
      ALU_ADD:  alu_next = bus.rd1 + op_b_next;
      ALU_XOR:  alu_next = bus.rd1 ^ op_b_next;
      ALU_SLL:  alu_next = bus.rd1 << shamt;
      ALU_SRL:  alu_next = bus.rd1 >> shamt;
      ALU_SUB:  alu_next = bus.rd1 - op_b_next;
      ALU_SLT:  alu_next = {{(XLEN-1){1'b0}}, ($signed(bus.rd1) < $signed(op_b_next))};
      ALU_SLTU: alu_next = {{(XLEN-1){1'b0}}, (bus.rd1 < op_b_next)};
      ALU_SRA:  alu_next = $unsigned($signed(bus.rd1) >>> shamt);
      default:  alu_next = '0;
    endcase
  end

  assign zero_next = (alu_next == '0);

`ifdef EXEC_BRANCH_COND_EN
  logic [XLEN-1:0] br_diff;
  logic            br_eq;
  logic            br_lt;
  logic            br_ltu;

  assign br_diff = bus.rd1 - op_b_next;
  assign br_eq   = (br_diff == '0);
  assign br_lt   = $signed(bus.rd1) < $signed(op_b_next);
  assign br_ltu  = bus.rd1 < op_b_next;

  always_comb begin
    branch_next = 1'b0;
    if (bus.alu_op == 2'b01) begin
      case (bus.funct3)
        3'b000: branch_next = br_eq;
        3'b001: branch_next = !br_eq;
        3'b100: branch_next = br_lt;
        3'b101: branch_next = !br_lt;
        3'b110: branch_next = br_ltu;
        3'b111: branch_next = !br_ltu;
        default: branch_next = 1'b0;
      endcase
    end
  end
`else
  // Only BEQ is resolved here; the ALU already subtracts for alu_op 01
  assign branch_next = (bus.alu_op == 2'b01) && zero_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_reg   <= '0;
      alu_reg    <= '0;
      adder_reg  <= '0;
      op_b_reg   <= '0;
      zero_reg   <= 1'b0;
      branch_reg <= 1'b0;
    end else if (!bus.stall) begin
      ctrl_reg   <= ctrl_next;
      alu_reg    <= alu_next;
      adder_reg  <= adder_next;
      op_b_reg   <= op_b_next;
      zero_reg   <= zero_next;
      branch_reg <= branch_next;
    end
  end

  assign bus.alu_ctrl     = ctrl_reg;
  assign bus.result_alu   = alu_reg;
  assign bus.result_adder = adder_reg;
  assign bus.muxout       = op_b_reg;
  assign bus.zero         = zero_reg;
  assign bus.branch_taken = branch_reg;
endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: reference model results are queued at drive time and compared after the edge.
module tb_exec_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exec_stage_if #(.XLEN(32)) bus ();

  exec_stage #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] adder;
    logic [3:0]  ctrl;
    logic [31:0] alu;
    logic        zero;
    logic [31:0] mux;
    logic        br;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_exp;
  int   checks   = 0;
  int   failures = 0;
  int   txn      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic src, input logic [2:0] f3,
                                 input logic f7, input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [31:0] a, input logic [31:0] rb);
    exp_t e;
    logic [31:0] b;
    b = src ? imm : rb;
    e.mux   = b;
    e.adder = pc + imm;
    if (op == 2'b00)      e.ctrl = 4'd2;
    else if (op == 2'b01) e.ctrl = 4'd6;
    else begin
      case (f3)
        3'd0: e.ctrl = (op == 2'b10 && f7) ? 4'd6 : 4'd2;
        3'd1: e.ctrl = 4'd4;
        3'd2: e.ctrl = 4'd7;
        3'd3: e.ctrl = 4'd8;
        3'd4: e.ctrl = 4'd3;
        3'd5: e.ctrl = f7 ? 4'd9 : 4'd5;
        3'd6: e.ctrl = 4'd1;
        default: e.ctrl = 4'd0;
      endcase
    end
    case (e.ctrl)
      4'd0: e.alu = a & b;
      4'd1: e.alu = a | b;
      4'd2: e.alu = a + b;
      4'd3: e.alu = a ^ b;
      4'd4: e.alu = a << b[4:0];
      4'd5: e.alu = a >> b[4:0];
      4'd6: e.alu = a - b;
      4'd7: e.alu = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
      4'd8: e.alu = {31'd0, (a < b)};
      default: begin
        e.alu = a >> b[4:0];
        for (int i = 0; i < 32; i++)
          if (i >= 32 - int'(b[4:0])) e.alu[i] = a[31];
      end
    endcase
    e.zero = (e.alu == 32'd0);
    e.br = 1'b0;
    if (op == 2'b01) begin
`ifdef EXEC_BRANCH_COND_EN
      case (f3)
        3'd0: e.br = (a == b);
        3'd1: e.br = (a != b);
        3'd4: e.br = ($signed(a) < $signed(b));
        3'd5: e.br = ($signed(a) >= $signed(b));
        3'd6: e.br = (a < b);
        3'd7: e.br = (a >= b);
        default: e.br = 1'b0;
      endcase
`else
      e.br = (a == b);
`endif
    end
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e);
    check({tag, ".adder"}, bus.result_adder, e.adder);
    check({tag, ".ctrl"},  {28'd0, bus.alu_ctrl}, {28'd0, e.ctrl});
    check({tag, ".alu"},   bus.result_alu, e.alu);
    check({tag, ".zero"},  {31'd0, bus.zero}, {31'd0, e.zero});
    check({tag, ".mux"},   bus.muxout, e.mux);
    check({tag, ".br"},    {31'd0, bus.branch_taken}, {31'd0, e.br});
  endtask

  task automatic drive(input string tag, input logic r, input logic s, input logic [1:0] op,
                       input logic src, input logic [2:0] f3, input logic f7,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] a, input logic [31:0] rb);
    exp_t e;
    rst = r;  bus.stall = s; bus.alu_op = op; bus.alu_src = src;
    bus.funct3 = f3; bus.funct7_30 = f7; bus.pc = pc; bus.imm = imm;
    bus.rd1 = a; bus.rd2 = rb;
    if (r) cur_exp = '{32'd0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0};
    else if (!s) cur_exp = model(op, src, f3, f7, pc, imm, a, rb);
    exp_q.push_back(cur_exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    txn++;
    $display("txn %0d %s rst=%0b stall=%0b op=%0d f3=%0d ctrl=%h alu=%h adder=%h br=%0b",
             txn, tag, r, s, op, f3, bus.alu_ctrl, bus.result_alu, bus.result_adder, bus.branch_taken);
    compare(tag, e);
  endtask

  initial begin
    rst = 1'b0; bus.stall = 1'b0; bus.alu_op = 2'b00; bus.alu_src = 1'b0;
    bus.funct3 = 3'd0; bus.funct7_30 = 1'b0; bus.pc = '0; bus.imm = '0;
    bus.rd1 = '0; bus.rd2 = '0;
    @(negedge clk);

    drive("reset",  1, 0, 2'b10, 0, 3'd3, 1, 32'h1234, 32'h55, 32'hDEAD, 32'hBEEF);
    drive("add",    0, 0, 2'b10, 0, 3'd0, 0, 32'h0, 32'h0, 32'h40, 32'h80);
    drive("and",    0, 0, 2'b10, 0, 3'd7, 0, 32'h0, 32'h0, 32'h40, 32'h40);
    drive("addi",   0, 0, 2'b11, 1, 3'd0, 1, 32'h0, 32'h40, 32'h40, 32'h0);
    drive("sub",    0, 0, 2'b10, 0, 3'd0, 1, 32'h0, 32'h0, 32'h40, 32'h40);
    drive("beq",    0, 0, 2'b01, 0, 3'd0, 0, 32'h100, 32'hFFFFFFF8, 32'd5, 32'd5);
    drive("stall",  0, 1, 2'b01, 0, 3'd0, 0, 32'h100, 32'hFFFFFFF8, 32'd5, 32'd6);

    // inputs moving between edges must not reach the outputs
    bus.rd1 = 32'h777; bus.alu_op = 2'b10;
    #3;
    compare("midcycle", cur_exp);
    @(negedge clk);

    drive("slt_neg", 0, 0, 2'b10, 0, 3'd2, 0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'd1);
    drive("sltu",    0, 0, 2'b10, 0, 3'd3, 0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'd1);
    drive("sra",     0, 0, 2'b10, 0, 3'd5, 1, 32'h0, 32'h0, 32'h80000000, 32'hFFFFFFE4);
    drive("srli",    0, 0, 2'b11, 1, 3'd5, 0, 32'h0, 32'h1F, 32'h80000000, 32'h0);
    drive("ovf",     0, 0, 2'b00, 1, 3'd7, 1, 32'hFFFFFFFC, 32'h8, 32'hFFFFFFFF, 32'h0);
    drive("bne_op",  0, 0, 2'b01, 0, 3'd1, 0, 32'h200, 32'h10, 32'd3, 32'd9);
    drive("blt_op",  0, 0, 2'b01, 0, 3'd4, 0, 32'h200, 32'h10, 32'hFFFFFFF0, 32'd1);
    drive("rst_stl", 1, 1, 2'b10, 0, 3'd0, 0, 32'h9, 32'h9, 32'h9, 32'h9);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, rb;
      a  = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? a : $urandom;
      drive("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 4) == 0),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), $urandom, $urandom, a, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
